alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
// Initiator side of the combinational ALU interface (en/op/a/b -> result/overflow/carry/zero).
// Accepts ALU commands on a valid/ready stream, buffers them in a small FIFO and issues one
// at a time to the ALU. Samples result and flags, then returns them on a valid/ready response
// stream. Optional accumulator chaining replaces operand A with the previous result.
// PARAMETERS
// W      4  operand/result width; must match the ALU
// DEPTH  2  command FIFO entries; power of 2, >=2
// PORTS
// clk          in   1  system clock, rising edge
// rst_n        in   1  asynchronous, active-low reset
// cmd_valid    in   1  command present
// cmd_ready    out  1  FIFO can accept; equals !full
// cmd_op       in   3  ALU opcode, passed through unchanged
// cmd_a        in   W  operand A
// cmd_b        in   W  operand B
// cmd_use_acc  in   1  1: operand A = acc instead of cmd_a
// alu_en       out  1  ALU enable
// alu_op       out  3  registered opcode to ALU
// alu_a        out  W  registered operand A to ALU
// alu_b        out  W  registered operand B to ALU
// alu_result   in   W  ALU result
// alu_overflow in   1  ALU overflow flag
// alu_carry    in   1  ALU carry flag
// alu_zero     in   1  ALU zero flag
// rsp_valid    out  1  response present
// rsp_ready    in   1  consumer accepts response
// rsp_result   out  W  captured result
// rsp_flags    out  3  captured {overflow, carry, zero}
// busy         out  1  FIFO non-empty or FSM not IDLE
// BEHAVIOUR
// - Reset: FIFO emptied, state IDLE, alu_en/rsp_valid/busy=0, alu_op/a/b=0, rsp_result/flags=0, acc=0.
//   Reset mid-operation drops all queued commands and any pending response.
// - Command accept: cmd_valid && cmd_ready at a rising edge pushes {op,a,b,use_acc}.
//   cmd_ready is registered-free: cmd_ready = (count != DEPTH). No push while full.
// - FSM states IDLE, ISSUE, RESP:
//   IDLE:  FIFO non-empty -> pop head; load alu_op, alu_b, and alu_a = use_acc ? acc : a;
//          alu_en<=1; go ISSUE. An entry pushed in cycle N is poppable at the earliest in N+1.
//   ISSUE: alu_en=1 for exactly this cycle. At its end: capture alu_result/flags into rsp_*,
//          acc<=alu_result, alu_en<=0, rsp_valid<=1; go RESP.
//   RESP:  rsp_valid held with rsp_* stable until rsp_ready. On handshake: rsp_valid<=0; if FIFO
//          non-empty (including an entry pushed earlier) pop and load as in IDLE, go ISSUE,
//          else go IDLE.
// - alu_op/a/b hold their last value when alu_en=0.
// - Latency: push edge at end of cycle 0 -> alu_en=1 in cycle 2 -> rsp_valid=1 in cycle 3.
//   Sustained throughput with rsp_ready=1 is one op per 2 cycles.
// - Push and pop in the same cycle: both take effect and count is unchanged.
//   FIFO pointers wrap modulo DEPTH.
// - acc updates only on ISSUE capture, for every op, including compare/equal results.
// - use_acc resolves at pop time, so chained commands see the immediately preceding result.
// - busy = (count!=0) || (state!=IDLE).
// TESTING (op: 000 add, 001 sub, 010 not, 011 and, 100 or, 101 xor, 110 slt, 111 eq)
// 1 add a=0111 b=0001, rsp_ready=1 -> alu_en high in cycle 2; rsp_valid in cycle 3;
//   result=1000, flags=100.
// 2 sub a=0011 b=0011 -> result=0000, flags=011. Then use_acc=1 add b=0101 -> alu_a=0000,
//   result=0101, flags=000.
// 3 push DEPTH+1 cmds, rsp_ready=0 -> cmd_ready=0 after FIFO fills; rsp_* stable while stalled;
//   releasing rsp_ready drains all responses in order.
// 4 slt a=1000 b=0001 -> result=0001; eq a=0101 b=0101 -> result=0001, flags=000.
// 5 rst_n low while in RESP with 1 queued -> rsp_valid=0, busy=0, cmd_ready=1, acc=0 immediately;
//   no response after release.
// 6 continuous push, simultaneous push/pop at count=1 -> count stays 1; pointer wrap verified
//   over 10 ops against a reference model.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for a combinational ALU: queues commands in a small FIFO, issues them
// one at a time, and returns each sampled result and its flags on a valid/ready response stream.
module alu_cmd_sequencer #(
  parameter int W     = 4,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic         cmd_use_acc,
  output logic         alu_en,
  output logic [2:0]   alu_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_result,
  input  logic         alu_overflow,
  input  logic         alu_carry,
  input  logic         alu_zero,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic [2:0]   rsp_flags,
  output logic         busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 1 + 3 + 2 * W;

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    state_q, state_d;

  logic          alu_en_q, alu_en_d;
  logic [2:0]    alu_op_q, alu_op_d;
  logic [W-1:0]  alu_a_q, alu_a_d;
  logic [W-1:0]  alu_b_q, alu_b_d;
  logic [W-1:0]  acc_q, acc_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [W-1:0]  rsp_result_q, rsp_result_d;
  logic [2:0]    rsp_flags_q, rsp_flags_d;

  logic          push_s;
  logic          pop_s;
  logic          fifo_empty_s;
  logic [EW-1:0] head_s;
  logic          head_use_acc_s;
  logic [2:0]    head_op_s;
  logic [W-1:0]  head_a_s;
  logic [W-1:0]  head_b_s;

  assign push_s       = cmd_valid && (count_q != CNT_FULL);
  assign fifo_empty_s = (count_q == {CW{1'b0}});
  assign head_s       = mem_q[rd_ptr_q];
  assign {head_use_acc_s, head_op_s, head_a_s, head_b_s} = head_s;

  // Sequencer FSM: pop/load in IDLE or on response handshake, capture at end of ISSUE.
  always_comb begin
    state_d      = state_q;
    pop_s        = 1'b0;
    alu_en_d     = alu_en_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    acc_d        = acc_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s    = 1'b1;
          alu_en_d = 1'b1;
          alu_op_d = head_op_s;
          alu_b_d  = head_b_s;
          alu_a_d  = head_use_acc_s ? acc_q : head_a_s;
          state_d  = ST_ISSUE;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        alu_en_d     = 1'b0;
        rsp_valid_d  = 1'b1;
        rsp_result_d = alu_result;
        rsp_flags_d  = {alu_overflow, alu_carry, alu_zero};
        acc_d        = alu_result;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!fifo_empty_s) begin
            // Back-to-back issue keeps throughput at one op per two cycles.
            pop_s    = 1'b1;
            alu_en_d = 1'b1;
            alu_op_d = head_op_s;
            alu_b_d  = head_b_s;
            alu_a_d  = head_use_acc_s ? acc_q : head_a_s;
            state_d  = ST_ISSUE;
          end else begin
            state_d  = ST_IDLE;
          end
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        alu_en_d    = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // FIFO pointer and occupancy update; simultaneous push and pop leave count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {EW{1'b0}};
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= {cmd_use_acc, cmd_op, cmd_a, cmd_b};
    end
  end

  // State, pointer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= {AW{1'b0}};
      rd_ptr_q     <= {AW{1'b0}};
      count_q      <= {CW{1'b0}};
      state_q      <= ST_IDLE;
      alu_en_q     <= 1'b0;
      alu_op_q     <= 3'b000;
      alu_a_q      <= {W{1'b0}};
      alu_b_q      <= {W{1'b0}};
      acc_q        <= {W{1'b0}};
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= {W{1'b0}};
      rsp_flags_q  <= 3'b000;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      alu_en_q     <= alu_en_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      acc_q        <= acc_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  assign cmd_ready  = (count_q != CNT_FULL);
  assign alu_en     = alu_en_q;
  assign alu_op     = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign busy       = !fifo_empty_s || (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural ALU, in-order response model with accumulator,
// directed latency/chaining/backpressure/reset steps plus a randomized burst.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_use_acc;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a, cmd_b;
  logic       alu_en;
  logic [2:0] alu_op;
  logic [3:0] alu_a, alu_b, alu_result;
  logic       alu_overflow, alu_carry, alu_zero;
  logic       rsp_valid, rsp_ready;
  logic [3:0] rsp_result;
  logic [2:0] rsp_flags;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  int n_rsp = 0;

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic [2:0] fl;
  } exp_t;

  exp_t       iss_q[$];
  exp_t       rsp_q[$];
  exp_t       mon_e;
  logic [3:0] m_acc = 4'd0;
  logic       held_v = 1'b0;
  logic [3:0] held_res;
  logic [2:0] held_fl;

  alu_cmd_sequencer #(.W(4), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .alu_en(alu_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .alu_carry(alu_carry), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
  );

  always #5 clk = ~clk;

  // Returns {overflow, carry, zero, result}.
  function automatic logic [6:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] r;
    logic ov, c;
    ov = 1'b0; c = 1'b0; s = 5'd0; r = 4'd0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4]; ov = (a[3] == b[3]) && (r[3] != a[3]); end
      3'd1: begin r = a - b; c = (a >= b); ov = (a[3] != b[3]) && (r[3] != a[3]); end
      3'd2: r = ~a;
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: r = ($signed(a) < $signed(b)) ? 4'd1 : 4'd0;
      default: r = (a == b) ? 4'd1 : 4'd0;
    endcase
    return {ov, c, (r == 4'd0), r};
  endfunction

  // Combinational ALU; drives junk when disabled so off-cycle sampling shows up.
  always_comb begin
    if (alu_en) {alu_overflow, alu_carry, alu_zero, alu_result} = alu_f(alu_op, alu_a, alu_b);
    else        {alu_overflow, alu_carry, alu_zero, alu_result} = {3'b101, 4'hA};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_push(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic ua);
    exp_t e;
    e.op = op;
    e.a  = ua ? m_acc : a;
    e.b  = b;
    {e.fl, e.res} = alu_f(op, e.a, b);
    m_acc = e.res;
    iss_q.push_back(e);
    rsp_q.push_back(e);
  endtask

  task automatic push(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic ua);
    bit done;
    done = 1'b0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua; cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      done = cmd_ready;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (done) model_push(op, a, b, ua);
    chk("push_accept", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_rsp(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (rsp_valid) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 60 && busy; i++) begin
      @(posedge clk); #1;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  // Monitor: issued operands, response order/content, and response stability under stall.
  always @(negedge clk) begin
    if (!rst_n) begin
      held_v <= 1'b0;
    end else begin
      if (alu_en) begin
        if (iss_q.size() == 0) chk("issue_unexpected", 32'd1, 32'd0);
        else begin
          mon_e = iss_q.pop_front();
          chk("issue_op", {29'd0, alu_op}, {29'd0, mon_e.op});
          chk("issue_a",  {28'd0, alu_a},  {28'd0, mon_e.a});
          chk("issue_b",  {28'd0, alu_b},  {28'd0, mon_e.b});
        end
      end
      if (rsp_valid && held_v) begin
        chk("rsp_stable_res", {28'd0, rsp_result}, {28'd0, held_res});
        chk("rsp_stable_fl",  {29'd0, rsp_flags},  {29'd0, held_fl});
      end
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        if (rsp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
        else begin
          mon_e = rsp_q.pop_front();
          chk("rsp_result", {28'd0, rsp_result}, {28'd0, mon_e.res});
          chk("rsp_flags",  {29'd0, rsp_flags},  {29'd0, mon_e.fl});
        end
      end
      held_v   <= rsp_valid && !rsp_ready;
      held_res <= rsp_result;
      held_fl  <= rsp_flags;
    end
  end

  initial begin
    int base;
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = 3'd0; cmd_a = 4'd0; cmd_b = 4'd0; cmd_use_acc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_alu_en",    {31'd0, alu_en},    32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_alu_opab",  {21'd0, alu_op, alu_a, alu_b}, 32'd0);
    chk("rst_rsp",       {25'd0, rsp_flags, rsp_result}, 32'd0);
    rst_n = 1'b1;

    // Latency: push at end of cycle 0, alu_en in cycle 2, rsp_valid in cycle 3.
    @(posedge clk); #1;
    cmd_op = 3'd0; cmd_a = 4'b0111; cmd_b = 4'b0001; cmd_use_acc = 1'b0;
    cmd_valid = 1'b1; rsp_ready = 1'b1;
    model_push(3'd0, 4'b0111, 4'b0001, 1'b0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("lat_c1_alu_en", {31'd0, alu_en}, 32'd0);
    chk("lat_c1_busy",   {31'd0, busy},   32'd1);
    @(posedge clk); #1;
    chk("lat_c2_alu_en", {31'd0, alu_en}, 32'd1);
    chk("lat_c2_rsp_v",  {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_c3_rsp_v",  {31'd0, rsp_valid}, 32'd1);
    chk("lat_c3_alu_en", {31'd0, alu_en}, 32'd0);
    chk("add_result",    {28'd0, rsp_result}, 32'h8);
    chk("add_flags",     {29'd0, rsp_flags},  32'h4);
    @(posedge clk); #1;
    chk("lat_c4_rsp_v",  {31'd0, rsp_valid}, 32'd0);
    chk("lat_c4_busy",   {31'd0, busy}, 32'd0);

    // Sub to zero, then chain through the accumulator.
    push(3'd1, 4'b0011, 4'b0011, 1'b0);
    wait_rsp("sub_wait");
    chk("sub_result", {28'd0, rsp_result}, 32'h0);
    chk("sub_flags",  {29'd0, rsp_flags},  32'h3);
    push(3'd0, 4'b1111, 4'b0101, 1'b1);
    wait_rsp("acc_wait");
    chk("acc_alu_a",  {28'd0, alu_a},      32'h0);
    chk("acc_result", {28'd0, rsp_result}, 32'h5);
    chk("acc_flags",  {29'd0, rsp_flags},  32'h0);

    // Compare ops.
    push(3'd6, 4'b1000, 4'b0001, 1'b0);
    wait_rsp("slt_wait");
    chk("slt_result", {28'd0, rsp_result}, 32'h1);
    push(3'd7, 4'b0101, 4'b0101, 1'b0);
    wait_rsp("eq_wait");
    chk("eq_result",  {28'd0, rsp_result}, 32'h1);
    chk("eq_flags",   {29'd0, rsp_flags},  32'h0);
    wait_idle("pre_bp_idle");

    // Backpressure: DEPTH+1 commands with rsp_ready low.
    rsp_ready = 1'b0;
    base = n_rsp;
    push(3'd5, 4'b1100, 4'b1010, 1'b0);
    push(3'd3, 4'b1110, 4'b0111, 1'b0);
    chk("simul_push_pop_ready", {31'd0, cmd_ready}, 32'd1);
    push(3'd0, 4'b0001, 4'b0001, 1'b1);
    chk("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("stall_result",    {28'd0, rsp_result}, 32'h6);
    rsp_ready = 1'b1;
    wait_idle("bp_drain");
    chk("bp_rsp_count", n_rsp - base, 32'd3);
    chk("bp_queue_empty", rsp_q.size(), 32'd0);

    // Randomized continuous burst with accumulator chaining.
    base = n_rsp;
    for (int i = 0; i < 10; i++) begin
      push(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
    end
    wait_idle("rand_drain");
    chk("rand_rsp_count", n_rsp - base, 32'd10);
    chk("rand_queue_empty", rsp_q.size(), 32'd0);

    // Reset while holding a response with one command queued.
    rsp_ready = 1'b0;
    push(3'd4, 4'b0011, 4'b0100, 1'b0);
    push(3'd2, 4'b0110, 4'b0000, 1'b0);
    wait_rsp("pre_rst_wait");
    #2;
    rst_n = 1'b0;
    iss_q.delete();
    rsp_q.delete();
    m_acc = 4'd0;
    #1;
    chk("mrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mrst_busy",      {31'd0, busy},      32'd0);
    chk("mrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("mrst_alu_en",    {31'd0, alu_en},    32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    push(3'd0, 4'b1001, 4'b0011, 1'b1);
    wait_rsp("post_rst_acc_wait");
    chk("post_rst_acc_a",   {28'd0, alu_a},      32'h0);
    chk("post_rst_acc_res", {28'd0, rsp_result}, 32'h3);
    wait_idle("final_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
